// File: rtl/rrf_commit_n_pkg.sv
// Shared rename/retire types: register index widths and the per-lane commit record.
package rv32i_types;

  localparam int PHYS_BITS  = 6;
  localparam int ARCH_BITS  = 5;
  localparam int ARCH_COUNT = 2 ** ARCH_BITS;

  typedef struct packed {
    logic                 valid;
    logic                 regf_we;
    logic [ARCH_BITS-1:0] rd;
    logic [PHYS_BITS-1:0] pd;
  } commit_lane_t;

  // x0 is hardwired, so a commit to it neither remaps nor frees anything
  function automatic logic lane_writes(commit_lane_t l);
    return l.valid && l.regf_we && (l.rd != '0);
  endfunction

endpackage

// File: rtl/rrf_commit_n_if.sv
// Commit-side bundle between ROB, retirement register file, RAT restore and free list.
interface rrf_commit_n_if #(parameter int NSIZE = 1);

  logic [NSIZE-1:0]                     commit_valid;
  logic [NSIZE-1:0]                     commit_regf_we;
  logic [rv32i_types::ARCH_BITS-1:0]    commit_rd [NSIZE];
  logic [rv32i_types::PHYS_BITS-1:0]    commit_pd [NSIZE];
  logic                                 commit_ready;

  logic [rv32i_types::ARCH_BITS-1:0]    rrf_alias_rd [NSIZE];
  logic [rv32i_types::PHYS_BITS-1:0]    rrf_alias_pd [NSIZE];
  logic [NSIZE-1:0]                     rrf_alias_regf_we;

  logic                                 free_valid;
  logic [rv32i_types::PHYS_BITS-1:0]    free_pd;
  logic                                 free_ready;

  modport master (
    output commit_valid, commit_regf_we, commit_rd, commit_pd, free_ready,
    input  commit_ready, rrf_alias_rd, rrf_alias_pd, rrf_alias_regf_we,
           free_valid, free_pd
  );

  modport slave (
    input  commit_valid, commit_regf_we, commit_rd, commit_pd, free_ready,
    output commit_ready, rrf_alias_rd, rrf_alias_pd, rrf_alias_regf_we,
           free_valid, free_pd
  );

endinterface

// File: rtl/rrf_commit_n_free_ret_queue_n.sv
// Multi-push, single-pop circular FIFO holding physical registers on their way back to the free list.
module free_ret_queue_n #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  parameter int NPUSH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPUSH-1:0]           push_valid,
  input  logic [WIDTH-1:0]           push_data [NPUSH],
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    slot_off [NPUSH];
  logic [NPUSH-1:0] accept;
  logic [CW-1:0]    n_push;

  // Pack accepted lanes into consecutive slots; once full, later lanes are dropped
  always_comb begin
    n_push = '0;
    for (int i = 0; i < NPUSH; i++) begin
      slot_off[i] = n_push;
      accept[i]   = 1'b0;
      if (push_valid[i] && (int'(count) + int'(n_push) < DEPTH)) begin
        accept[i] = 1'b1;
        n_push    = n_push + CW'(1);
      end
    end
  end

  assign head_data = mem[head];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NPUSH; i++) begin
      if (accept[i]) mem[tail + PW'(slot_off[i])] <= push_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + PW'(1);
      tail  <= tail + PW'(n_push);
      count <= count + n_push - CW'(pop);
    end
  end

endmodule

// File: rtl/rrf_commit_n.sv
// Retirement register file: committed arch->phys map, RAT restore forwarding, old-mapping free return.
// Optional macro RRF_FREE_BYPASS_EN presents the first freed register combinationally when the queue is empty.
module rrf_commit_n
  import rv32i_types::*;
#(
  parameter int NSIZE       = 1,
  parameter int FREEQ_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rob_flush,
  rrf_commit_n_if.slave        bus,
  output logic [PHYS_BITS-1:0] RRF_out [ARCH_COUNT]
);

  localparam int CW = $clog2(FREEQ_DEPTH + 1);

  commit_lane_t         lane [NSIZE];
  logic [NSIZE-1:0]     eff;
  logic [NSIZE-1:0]     push_mask;
  logic [PHYS_BITS-1:0] old_pd [NSIZE];
  logic [PHYS_BITS-1:0] map [ARCH_COUNT];
  logic [PHYS_BITS-1:0] head_pd;
  logic [CW-1:0]        count;
  logic                 pop;
  logic                 unused_flush;

  // Flush leaves committed state alone: the map and pending frees are architecturally real
  assign unused_flush = rob_flush;

  always_comb begin
    for (int i = 0; i < NSIZE; i++) begin
      lane[i] = '{valid:   bus.commit_valid[i],
                  regf_we: bus.commit_regf_we[i],
                  rd:      bus.commit_rd[i],
                  pd:      bus.commit_pd[i]};
      eff[i]  = lane_writes(lane[i]);
      bus.rrf_alias_rd[i]      = lane[i].rd;
      bus.rrf_alias_pd[i]      = lane[i].pd;
      bus.rrf_alias_regf_we[i] = eff[i];
    end
  end

  // A lane displaces whatever an earlier lane in the same group just wrote, not the stale map entry
  always_comb begin
    for (int i = 0; i < NSIZE; i++) begin
      old_pd[i] = map[lane[i].rd];
      for (int j = 0; j < i; j++) begin
        if (eff[j] && (lane[j].rd == lane[i].rd)) old_pd[i] = lane[j].pd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < ARCH_COUNT; a++) map[a] <= PHYS_BITS'(a);
    end else begin
      for (int i = 0; i < NSIZE; i++) begin
        if (eff[i]) map[lane[i].rd] <= lane[i].pd;
      end
    end
  end

  assign RRF_out          = map;
  assign bus.commit_ready = (FREEQ_DEPTH - int'(count)) >= NSIZE;

`ifdef RRF_FREE_BYPASS_EN
  logic [PHYS_BITS-1:0] first_old;
  logic [NSIZE-1:0]     first_mask;
  logic                 bypass;

  // The lowest writing lane is the one that would land at the queue head, so it is the one bypassed
  always_comb begin
    first_old  = '0;
    first_mask = '0;
    for (int i = NSIZE - 1; i >= 0; i--) begin
      if (eff[i]) begin
        first_old  = old_pd[i];
        first_mask = NSIZE'(1) << i;
      end
    end
    bypass         = (count == '0) && (|eff);
    bus.free_valid = (count != '0) || bypass;
    bus.free_pd    = bypass ? first_old : head_pd;
    push_mask      = (bypass && bus.free_ready) ? (eff & ~first_mask) : eff;
    pop            = (count != '0) && bus.free_ready;
  end
`else
  assign bus.free_valid = (count != '0);
  assign bus.free_pd    = head_pd;
  assign push_mask      = eff;
  assign pop            = bus.free_valid && bus.free_ready;
`endif

  free_ret_queue_n #(
    .WIDTH (PHYS_BITS),
    .DEPTH (FREEQ_DEPTH),
    .NPUSH (NSIZE)
  ) u_free_q (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_mask),
    .push_data  (old_pd),
    .pop        (pop),
    .head_data  (head_pd),
    .count      (count)
  );

endmodule

// File: tb/tb_rrf_commit_n.sv
// Bench for rrf_commit_n (NSIZE=2, FREEQ_DEPTH=8); also builds with RRF_FREE_BYPASS_EN defined.
module tb_rrf_commit_n;

  logic       clk;
  logic       rst;
  logic       rob_flush;
  logic [5:0] rrf_out [32];

  int checks   = 0;
  int failures = 0;

  logic [5:0] mmap [32];
  logic [5:0] fq [$];

  rrf_commit_n_if #(.NSIZE(2)) bus ();

  rrf_commit_n #(
    .NSIZE       (2),
    .FREEQ_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rob_flush (rob_flush),
    .bus       (bus),
    .RRF_out   (rrf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic bit laneEff(int i);
    return bus.commit_valid[i] && bus.commit_regf_we[i] && (bus.commit_rd[i] != 5'd0);
  endfunction

  // Reference: apply lanes one after another to a plain map; each displaced value is a free
  task automatic modelStep();
    int         pre;
    int         pushed;
    bit         took;
    logic [5:0] old;
    if (rst) begin
      for (int a = 0; a < 32; a++) mmap[a] = 6'(a);
      fq.delete();
      return;
    end
    pre    = fq.size();
    pushed = 0;
    took   = 1'b0;
    if (pre > 0 && bus.free_ready) void'(fq.pop_front());
    for (int i = 0; i < 2; i++) begin
      if (laneEff(i)) begin
        old = mmap[bus.commit_rd[i]];
        mmap[bus.commit_rd[i]] = bus.commit_pd[i];
`ifdef RRF_FREE_BYPASS_EN
        if (pre == 0 && bus.free_ready && !took) took = 1'b1;
        else
`endif
        if (pre + pushed < 8) begin
          fq.push_back(old);
          pushed++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic setCommit(logic [1:0] v, logic [1:0] we,
                           logic [4:0] rd0, logic [5:0] pd0,
                           logic [4:0] rd1, logic [5:0] pd1);
    bus.commit_valid   = v;
    bus.commit_regf_we = we;
    bus.commit_rd[0]   = rd0;
    bus.commit_pd[0]   = pd0;
    bus.commit_rd[1]   = rd1;
    bus.commit_pd[1]   = pd1;
  endtask

  task automatic applyStimulus(logic [1:0] v, logic [1:0] we,
                               logic [4:0] rd0, logic [5:0] pd0,
                               logic [4:0] rd1, logic [5:0] pd1);
    setCommit(v, we, rd0, pd0, rd1, pd1);
    tick();
    setCommit(2'b00, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
  endtask

  // Every cycle out of reset, the DUT must agree with the reference map/queue
  always @(negedge clk) begin : cmp
    int         nbad;
    bit         exp_fv;
    logic [5:0] exp_pd;
    if (!rst) begin
      nbad = 0;
      for (int a = 0; a < 32; a++) if (rrf_out[a] !== mmap[a]) nbad++;
      checkOutput("rrf_map_mismatches", nbad, 0);
      checkOutput("commit_ready", int'(bus.commit_ready), ((8 - fq.size()) >= 2) ? 1 : 0);
      exp_fv = (fq.size() != 0);
      exp_pd = (fq.size() != 0) ? fq[0] : 6'd0;
`ifdef RRF_FREE_BYPASS_EN
      if (fq.size() == 0) begin
        for (int i = 1; i >= 0; i--) begin
          if (laneEff(i)) begin
            exp_fv = 1'b1;
            exp_pd = mmap[bus.commit_rd[i]];
          end
        end
      end
`endif
      checkOutput("free_valid", int'(bus.free_valid), int'(exp_fv));
      if (exp_fv) checkOutput("free_pd", int'(bus.free_pd), int'(exp_pd));
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("alias_rd%0d", i), int'(bus.rrf_alias_rd[i]), int'(bus.commit_rd[i]));
        checkOutput($sformatf("alias_pd%0d", i), int'(bus.rrf_alias_pd[i]), int'(bus.commit_pd[i]));
        checkOutput($sformatf("alias_we%0d", i), int'(bus.rrf_alias_regf_we[i]), int'(laneEff(i)));
      end
      if (|bus.commit_valid) checkOutput("protocol_commit_ready", int'(bus.commit_ready), 1);
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    rob_flush      = 1'b0;
    bus.free_ready = 1'b0;
    setCommit(2'b00, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_map5", int'(rrf_out[5]), 5);
    checkOutput("reset_free_valid", int'(bus.free_valid), 0);
    checkOutput("reset_commit_ready", int'(bus.commit_ready), 1);

    // Single commit, rd=5 -> pd=40, frees the identity mapping 5
    bus.free_ready = 1'b1;
    applyStimulus(2'b01, 2'b01, 5'd5, 6'd40, 5'd0, 6'd0);
    checkOutput("commit5_map", int'(rrf_out[5]), 40);
    checkOutput("commit5_model_map", int'(mmap[5]), 40);
`ifndef RRF_FREE_BYPASS_EN
    checkOutput("commit5_free_valid", int'(bus.free_valid), 1);
    checkOutput("commit5_free_pd", int'(bus.free_pd), 5);
`endif
    tick();
    checkOutput("commit5_drained", int'(bus.free_valid), 0);

    // x0 write: no remap, no free
    setCommit(2'b01, 2'b01, 5'd0, 6'd41, 5'd0, 6'd0);
    #1;
    checkOutput("x0_alias_we", int'(bus.rrf_alias_regf_we[0]), 0);
    checkOutput("x0_alias_pd", int'(bus.rrf_alias_pd[0]), 41);
    tick();
    setCommit(2'b00, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
    checkOutput("x0_map", int'(rrf_out[0]), 0);
    checkOutput("x0_no_free", int'(bus.free_valid), 0);

    // Two lanes to the same rd: highest lane wins, frees 7 then 50
    bus.free_ready = 1'b0;
    applyStimulus(2'b11, 2'b11, 5'd7, 6'd50, 5'd7, 6'd51);
    checkOutput("same_rd_map7", int'(rrf_out[7]), 51);
    checkOutput("same_rd_free0", int'(bus.free_pd), 7);
    checkOutput("same_rd_model_q", fq.size(), 2);
    bus.free_ready = 1'b1;
    tick();
    checkOutput("same_rd_free1", int'(bus.free_pd), 50);
    tick();
    checkOutput("same_rd_empty", int'(bus.free_valid), 0);

    // Fill the queue with free_ready low, then drain in commit order
    bus.free_ready = 1'b0;
    for (int k = 0; k < 6; k++) applyStimulus(2'b01, 2'b01, 5'(10 + k), 6'(20 + k), 5'd0, 6'd0);
    checkOutput("fill6_ready", int'(bus.commit_ready), 1);
    applyStimulus(2'b11, 2'b11, 5'd16, 6'd26, 5'd17, 6'd27);
    checkOutput("fill8_ready", int'(bus.commit_ready), 0);
    checkOutput("fill8_model_q", fq.size(), 8);
    bus.free_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("drain_pd%0d", k), int'(bus.free_pd), 10 + k);
      tick();
      if (k == 0) checkOutput("drain_count7_ready", int'(bus.commit_ready), 0);
      if (k == 1) checkOutput("drain_count6_ready", int'(bus.commit_ready), 1);
    end
    checkOutput("drain_done", int'(bus.free_valid), 0);

    // Commit in the flush cycle is applied and its free is kept
    bus.free_ready = 1'b0;
    rob_flush      = 1'b1;
    setCommit(2'b01, 2'b01, 5'd3, 6'd60, 5'd0, 6'd0);
    #1;
    checkOutput("flush_alias_rd", int'(bus.rrf_alias_rd[0]), 3);
    checkOutput("flush_alias_pd", int'(bus.rrf_alias_pd[0]), 60);
    checkOutput("flush_alias_we", int'(bus.rrf_alias_regf_we[0]), 1);
    tick();
    setCommit(2'b00, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
    rob_flush = 1'b0;
    checkOutput("flush_map3", int'(rrf_out[3]), 60);
    tick();
    checkOutput("flush_free_kept", int'(bus.free_pd), 3);
    bus.free_ready = 1'b1;
    tick();
    checkOutput("flush_free_gone", int'(bus.free_valid), 0);

    // Lane 0 targets x0, lane 1 writes; then a chained pair on rd 9
    bus.free_ready = 1'b0;
    applyStimulus(2'b11, 2'b11, 5'd0, 6'd45, 5'd9, 6'd46);
    checkOutput("mix_map9", int'(rrf_out[9]), 46);
    checkOutput("mix_map0", int'(rrf_out[0]), 0);
    applyStimulus(2'b11, 2'b11, 5'd9, 6'd47, 5'd9, 6'd48);
    checkOutput("chain_map9", int'(rrf_out[9]), 48);
    bus.free_ready = 1'b1;
    checkOutput("chain_free0", int'(bus.free_pd), 9);
    tick();
    checkOutput("chain_free1", int'(bus.free_pd), 46);
    tick();
    checkOutput("chain_free2", int'(bus.free_pd), 47);
    tick();

    // Reset mid-operation discards queued frees and restores identity
    bus.free_ready = 1'b0;
    applyStimulus(2'b01, 2'b01, 5'd12, 6'd33, 5'd0, 6'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_map12", int'(rrf_out[12]), 12);
    checkOutput("rst_mid_free_valid", int'(bus.free_valid), 0);
    checkOutput("rst_mid_ready", int'(bus.commit_ready), 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
